// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle main controller: opcodes, FSM states,
// instruction classes and the mux/trap-cause codes driven to the datapath.
package ctrl_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_TRAP
  } state_t;

  typedef enum logic [3:0] {
    CLS_LOAD,
    CLS_STORE,
    CLS_OP,
    CLS_OP_IMM,
    CLS_BRANCH,
    CLS_JAL,
    CLS_JALR,
    CLS_LUI,
    CLS_AUIPC,
    CLS_NONE
  } instr_class_t;

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_DMEM = 2'b01;
  localparam logic [1:0] WB_PC4  = 2'b10;
  localparam logic [1:0] WB_IMM  = 2'b11;

  localparam logic [1:0] PC_PLUS4 = 2'b00;
  localparam logic [1:0] PC_IMM   = 2'b01;
  localparam logic [1:0] PC_ALU   = 2'b10;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

endpackage

// File: rtl/instr_classifier.sv
// Combinational RV32I opcode/funct3 classifier; flags encodings the core
// cannot execute so the controller can trap on them.
module instr_classifier
  import ctrl_pkg::*;
(
  input  logic [6:0]   opcode,
  input  logic [2:0]   funct3,
  output instr_class_t cls,
  output logic         legal
);

  always_comb begin
    cls   = CLS_NONE;
    legal = 1'b0;
    case (opcode)
      OPC_LOAD: begin
        cls   = CLS_LOAD;
        legal = (funct3 != 3'd3) && (funct3 < 3'd6);
      end
      OPC_STORE: begin
        cls   = CLS_STORE;
        legal = (funct3 <= 3'd2);
      end
      OPC_OP: begin
        cls   = CLS_OP;
        legal = 1'b1;
      end
      OPC_OP_IMM: begin
        cls   = CLS_OP_IMM;
        legal = 1'b1;
      end
      OPC_BRANCH: begin
        cls   = CLS_BRANCH;
        legal = (funct3 != 3'd2) && (funct3 != 3'd3);
      end
      OPC_JAL: begin
        cls   = CLS_JAL;
        legal = 1'b1;
      end
      OPC_JALR: begin
        cls   = CLS_JALR;
        legal = (funct3 == 3'd0);
      end
      OPC_LUI: begin
        cls   = CLS_LUI;
        legal = 1'b1;
      end
      OPC_AUIPC: begin
        cls   = CLS_AUIPC;
        legal = 1'b1;
      end
      default: begin
        cls   = CLS_NONE;
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_main_controller.sv
// Multi-cycle RV32I main controller: FETCH/DECODE/EXEC/MEM/WB sequencing with
// imem/dmem handshakes, Moore datapath controls, sticky trap and retire count.
//   state  | meaning
//   IDLE   | post-reset, controls off
//   FETCH  | imem_req until imem_ack, IR loads
//   DECODE | classify registered instruction
//   EXEC   | ALU operand select, sample branch_taken
//   MEM    | dmem_req until ack or timeout
//   WB     | register write, PC update, retire
//   TRAP   | sticky until reset
module multicycle_main_controller
  import ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int RETIRE_W    = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [6:0]          opcode,
  input  logic [2:0]          funct3,
  input  logic                branch_taken,
  output logic                imem_req,
  input  logic                imem_ack,
  output logic                dmem_req,
  output logic                dmem_we,
  input  logic                dmem_ack,
  output logic                ir_load,
  output logic                reg_w_en,
  output logic                alu_a_sel,
  output logic                reg_imm_sel,
  output logic [1:0]          wb_sel,
  output logic                pc_en,
  output logic [1:0]          pc_sel,
  output logic                trap,
  output logic [1:0]          trap_cause,
  output logic [RETIRE_W-1:0] retired
);

  localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  // Last non-ack MEM cycle before the count reaches MEM_TIMEOUT.
  localparam logic [CNT_W-1:0] WAIT_LAST = (MEM_TIMEOUT > 0) ? CNT_W'(MEM_TIMEOUT - 1) : '0;

  state_t              state, state_next;
  logic [6:0]          opcode_q;
  logic [2:0]          funct3_q;
  instr_class_t        cls_q, dec_cls;
  logic                dec_legal;
  logic                taken_q;
  logic [CNT_W-1:0]    wait_cnt;
  logic [1:0]          cause_q;
  logic [RETIRE_W-1:0] retired_q;

  instr_classifier u_classifier (
    .opcode (opcode_q),
    .funct3 (funct3_q),
    .cls    (dec_cls),
    .legal  (dec_legal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opcode_q  <= '0;
      funct3_q  <= '0;
      cls_q     <= CLS_NONE;
      taken_q   <= 1'b0;
      wait_cnt  <= '0;
      cause_q   <= CAUSE_NONE;
      retired_q <= '0;
    end else begin
      if (state == ST_FETCH && imem_ack) begin
        opcode_q <= opcode;
        funct3_q <= funct3;
      end
      if (state == ST_DECODE) cls_q <= dec_cls;
      if (state == ST_EXEC) begin
        taken_q  <= branch_taken;
        wait_cnt <= '0;
      end else if (state == ST_MEM && !dmem_ack && MEM_TIMEOUT != 0) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (state == ST_DECODE && state_next == ST_TRAP) cause_q <= CAUSE_ILLEGAL;
      if (state == ST_MEM && state_next == ST_TRAP)    cause_q <= CAUSE_TIMEOUT;
      if (state == ST_WB) retired_q <= retired_q + 1'b1;
    end
  end

  always_comb begin
    state_next  = state;
    imem_req    = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    ir_load     = 1'b0;
    reg_w_en    = 1'b0;
    alu_a_sel   = 1'b0;
    reg_imm_sel = 1'b0;
    wb_sel      = WB_ALU;
    pc_en       = 1'b0;
    pc_sel      = PC_PLUS4;
    trap        = 1'b0;
    case (state)
      ST_IDLE: state_next = ST_FETCH;
      ST_FETCH: begin
        // IR follows the bus for every FETCH cycle; the ack cycle's word is the last one latched.
        imem_req = 1'b1;
        ir_load  = 1'b1;
        if (imem_ack) state_next = ST_DECODE;
      end
      ST_DECODE: state_next = dec_legal ? ST_EXEC : ST_TRAP;
      ST_EXEC: begin
        reg_imm_sel = (cls_q == CLS_LOAD) || (cls_q == CLS_STORE) ||
                      (cls_q == CLS_OP_IMM) || (cls_q == CLS_JALR);
        alu_a_sel   = (cls_q == CLS_AUIPC);
        state_next  = (cls_q == CLS_LOAD || cls_q == CLS_STORE) ? ST_MEM : ST_WB;
      end
      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (cls_q == CLS_STORE);
        if (dmem_ack)                                           state_next = ST_WB;
        else if (MEM_TIMEOUT != 0 && wait_cnt == WAIT_LAST)     state_next = ST_TRAP;
      end
      ST_WB: begin
        pc_en    = 1'b1;
        reg_w_en = !(cls_q == CLS_STORE || cls_q == CLS_BRANCH);
        if (cls_q == CLS_LOAD)                            wb_sel = WB_DMEM;
        else if (cls_q == CLS_JAL || cls_q == CLS_JALR)   wb_sel = WB_PC4;
        else if (cls_q == CLS_LUI)                        wb_sel = WB_IMM;
        if (cls_q == CLS_JAL)                             pc_sel = PC_IMM;
        else if (cls_q == CLS_JALR)                       pc_sel = PC_ALU;
        else if (cls_q == CLS_BRANCH && taken_q)          pc_sel = PC_IMM;
        state_next = ST_FETCH;
      end
      ST_TRAP: trap = 1'b1;
      default: state_next = ST_IDLE;
    endcase
  end

  assign trap_cause = cause_q;
  assign retired    = retired_q;

endmodule

// File: tb/tb_multicycle_main_controller.sv
// Self-checking bench: per-cycle expected control vectors derived from the
// instruction's class, memory wait counts and trap rules.
module tb_multicycle_main_controller;

  localparam int TMO = 4;
  localparam int RW  = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [6:0]    opcode = '0;
  logic [2:0]    funct3 = '0;
  logic          branch_taken = 1'b0;
  logic          imem_req, imem_ack = 1'b0;
  logic          dmem_req, dmem_we, dmem_ack = 1'b0;
  logic          ir_load, reg_w_en, alu_a_sel, reg_imm_sel, pc_en, trap;
  logic [1:0]    wb_sel, pc_sel, trap_cause;
  logic [RW-1:0] retired;

  int            n_assert = 0;
  int            n_fail = 0;
  logic [RW-1:0] ret_model = '0;
  logic [15:0]   obs;
  bit            trapped;

  always #5 clk = ~clk;

  multicycle_main_controller #(.MEM_TIMEOUT(TMO), .RETIRE_W(RW)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3),
    .branch_taken(branch_taken), .imem_req(imem_req), .imem_ack(imem_ack),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .ir_load(ir_load), .reg_w_en(reg_w_en), .alu_a_sel(alu_a_sel),
    .reg_imm_sel(reg_imm_sel), .wb_sel(wb_sel), .pc_en(pc_en), .pc_sel(pc_sel),
    .trap(trap), .trap_cause(trap_cause), .retired(retired)
  );

  assign obs = {imem_req, dmem_req, dmem_we, ir_load, reg_w_en, alu_a_sel,
                reg_imm_sel, wb_sel, pc_en, pc_sel, trap, trap_cause};

  function automatic logic [15:0] vec(input logic ireq, input logic dreq, input logic we,
                                      input logic irl, input logic rwe, input logic asel,
                                      input logic isel, input logic [1:0] wbs, input logic pce,
                                      input logic [1:0] pcs, input logic tr, input logic [1:0] cause);
    return {ireq, dreq, we, irl, rwe, asel, isel, wbs, pce, pcs, tr, cause};
  endfunction

  task automatic check(input string tag, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: controls observed %h expected %h", tag, obs, exp);
    end
    n_assert++;
    assert (retired === ret_model) else begin
      n_fail++;
      $error("FAIL %s_retired: observed %0d expected %0d", tag, retired, ret_model);
    end
  endtask

  task automatic noise();
    imem_ack     = 1'($urandom);
    dmem_ack     = 1'($urandom);
    branch_taken = 1'($urandom);
    opcode       = 7'($urandom);
    funct3       = 3'($urandom);
  endtask

  task automatic rst_tail();
    @(negedge clk); noise(); #1 check("rst_hold", '0);
    @(negedge clk); rst_n = 1'b1; noise(); #1 check("idle", '0);
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0; ret_model = '0; #1 check("rst_assert", '0);
    rst_tail();
  endtask

  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input int iw,
                           input int dw, input logic tk, input int rst_at, output bit trp);
    bit ld, st, opr, opi, br, jal, jalr, lui, aui, legal;
    logic [1:0] wbs, pcs;
    int mc;
    trp  = 1'b0;
    ld   = (op == 7'b0000011);  st  = (op == 7'b0100011);  opr = (op == 7'b0110011);
    opi  = (op == 7'b0010011);  br  = (op == 7'b1100011);  jal = (op == 7'b1101111);
    jalr = (op == 7'b1100111);  lui = (op == 7'b0110111);  aui = (op == 7'b0010111);
    legal = (ld && f3 != 3 && f3 != 6 && f3 != 7) || (st && f3 <= 2) || opr || opi ||
            (br && f3 != 2 && f3 != 3) || jal || (jalr && f3 == 0) || lui || aui;
    for (int i = 0; i <= iw; i++) begin
      @(negedge clk); noise();
      imem_ack = (i == iw);
      if (i == iw) begin opcode = op; funct3 = f3; end
      #1 check("fetch", vec(1,0,0,1,0,0,0,2'd0,0,2'd0,0,2'd0));
    end
    @(negedge clk); noise(); #1 check("decode", '0);
    if (!legal) begin
      for (int k = 0; k < 3; k++) begin
        @(negedge clk); noise(); #1 check("trap_illegal", vec(0,0,0,0,0,0,0,2'd0,0,2'd0,1,2'b01));
      end
      trp = 1'b1;
      return;
    end
    @(negedge clk); noise(); branch_taken = tk;
    #1 check("exec", vec(0,0,0,0,0,aui,ld|st|opi|jalr,2'd0,0,2'd0,0,2'd0));
    if (ld || st) begin
      mc = (dw < TMO) ? dw + 1 : TMO;
      for (int j = 0; j < mc; j++) begin
        @(negedge clk); noise(); dmem_ack = (j == dw);
        #1 check("mem", vec(0,1,st,0,0,0,0,2'd0,0,2'd0,0,2'd0));
        if (j == rst_at) begin
          #2 rst_n = 1'b0; ret_model = '0;
          #1 check("rst_mid_mem", '0);
          rst_tail();
          trp = 1'b1;
          return;
        end
      end
      if (dw >= TMO) begin
        for (int k = 0; k < 3; k++) begin
          @(negedge clk); noise(); #1 check("trap_timeout", vec(0,0,0,0,0,0,0,2'd0,0,2'd0,1,2'b10));
        end
        trp = 1'b1;
        return;
      end
    end
    wbs = ld ? 2'b01 : (jal || jalr) ? 2'b10 : lui ? 2'b11 : 2'b00;
    pcs = jal ? 2'b01 : jalr ? 2'b10 : (br && tk) ? 2'b01 : 2'b00;
    @(negedge clk); noise();
    #1 check("wb", vec(0,0,0,0,!(st || br),0,0,wbs,1,pcs,0,2'd0));
    ret_model = ret_model + 1'b1;
  endtask

  logic [6:0] op_tab [10];

  initial begin
    op_tab = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
               7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1111111};
    #1 check("reset", '0);
    rst_tail();

    run_instr(7'b0010011, 3'd0, 0, 0, 1'b0, -1, trapped);  // ADDI
    run_instr(7'b0000011, 3'd2, 0, 3, 1'b0, -1, trapped);  // LW, ack on 4th MEM cycle
    run_instr(7'b0100011, 3'd2, 0, 0, 1'b0, -1, trapped);  // SW
    run_instr(7'b1100011, 3'd0, 0, 0, 1'b1, -1, trapped);  // BEQ taken
    run_instr(7'b1100011, 3'd0, 1, 0, 1'b0, -1, trapped);  // BEQ not taken
    run_instr(7'b1101111, 3'd5, 0, 0, 1'b0, -1, trapped);  // JAL
    run_instr(7'b1100111, 3'd0, 2, 0, 1'b0, -1, trapped);  // JALR
    run_instr(7'b0110111, 3'd1, 0, 0, 1'b0, -1, trapped);  // LUI
    run_instr(7'b0010111, 3'd4, 0, 0, 1'b0, -1, trapped);  // AUIPC
    run_instr(7'b0110011, 3'd7, 0, 0, 1'b0, -1, trapped);  // OP

    run_instr(7'b0000011, 3'd0, 0, 9, 1'b0, -1, trapped);  // dmem timeout
    do_reset();
    run_instr(7'b1100111, 3'd1, 0, 0, 1'b0, -1, trapped);  // JALR funct3=1
    do_reset();
    run_instr(7'b1111111, 3'd0, 0, 0, 1'b0, -1, trapped);  // unknown opcode
    do_reset();
    run_instr(7'b0100011, 3'd0, 0, 9, 1'b0, 1, trapped);   // reset during MEM

    for (int n = 0; n < 16; n++) run_instr(7'b0010011, 3'd0, 0, 0, 1'b0, -1, trapped);
    @(negedge clk); imem_ack = 1'b0; #1;
    n_assert++;
    assert (retired === 4'd0) else begin
      n_fail++;
      $error("FAIL retire_wrap: observed %0d expected 0", retired);
    end

    for (int n = 0; n < 60; n++) begin
      logic [6:0] op;
      op = op_tab[$urandom_range(0, 9)];
      if (op == 7'b1111111) op = 7'($urandom);
      run_instr(op, 3'($urandom), $urandom_range(0, 2), $urandom_range(0, 5),
                1'($urandom), -1, trapped);
      if (trapped) do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_main_controller.md
# multicycle_main_controller

Parametrised multi-cycle successor to the core's single-cycle main decoder. It sequences each RV32I instruction through FETCH, DECODE, EXEC, MEM and WB with req/ack handshakes to instruction and data memory. It drives the register-file, ALU-operand, writeback-mux and PC-update controls, and traps on illegal encodings and data-memory timeouts. It sits between the IR/PC datapath and the memory ports, and counts retired instructions.

## Interface
- MEM_TIMEOUT, 16: max cycles waiting for dmem_ack in MEM; 0 disables the timeout.
- RETIRE_W, 32: width of the retired-instruction counter.
- clk  input  1  core clock.
- rst_n  input  1  asynchronous, active-low reset.
- opcode  input  7  instr[6:0], from the instruction bus; valid in the cycle imem_ack is high.
- funct3  input  3  instr[14:12]; same validity as opcode.
- branch_taken  input  1  datapath comparator result; sampled in EXEC.
- imem_req  output  1  fetch request.
- imem_ack  input  1  fetch complete; instruction valid on the bus this cycle.
- dmem_req  output  1  data access request.
- dmem_we  output  1  0 = load, 1 = store.
- dmem_ack  input  1  data access complete.
- ir_load  output  1  latch the instruction into the IR.
- reg_w_en  output  1  register-file write enable.
- alu_a_sel  output  1  0 = rs1, 1 = PC.
- reg_imm_sel  output  1  ALU operand B: 0 = rs2, 1 = immediate.
- wb_sel  output  2  00 = ALU, 01 = dmem, 10 = PC+4, 11 = immediate.
- pc_en  output  1  PC update strobe.
- pc_sel  output  2  00 = PC+4, 01 = PC+imm, 10 = ALU result with bit 0 cleared.
- trap  output  1  sticky trap flag.
- trap_cause  output  2  00 = none, 01 = illegal instruction, 10 = dmem timeout.
- retired  output  RETIRE_W  count of retired instructions.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP.
- Outputs are Moore. Every output is a function of the state, the registered instruction class and the registered taken bit only. No input drives an output combinationally.
- **IDLE**: entered on reset; all controls 0; always moves to FETCH.
- **FETCH**: imem_req = 1. When imem_ack is high: ir_load = 1 that cycle, opcode/funct3 are registered, and the state moves to DECODE. Otherwise the state stays in FETCH.
- **DECODE**: registered opcode/funct3 are classified into LOAD (0000011), STORE (0100011), OP (0110011), OP_IMM (0010011), BRANCH (1100011), JAL (1101111), JALR (1100111), LUI (0110111) and AUIPC (0010111).
- **Illegal encodings**: any other opcode, LOAD funct3 of 3, 6 or 7, STORE funct3 above 2, BRANCH funct3 of 2 or 3, and JALR funct3 not 0. An illegal encoding moves to TRAP with cause 01. A legal one moves to EXEC.
- **EXEC**:
  - reg_imm_sel = 1 for LOAD, STORE, OP_IMM and JALR.
  - alu_a_sel = 1 for AUIPC.
  - branch_taken is registered.
  - LOAD and STORE move to MEM; every other class moves to WB.
- **MEM**: dmem_req = 1, and dmem_we = 1 for STORE.
  - dmem_ack moves to WB.
  - With MEM_TIMEOUT ≠ 0, the wait counter reaching MEM_TIMEOUT moves to TRAP with cause 10.
  - If dmem_ack arrives in the same cycle the counter reaches the limit, the ack wins.
- **WB**: pc_en = 1 and retired increments; the state then moves to FETCH.
  - reg_w_en = 1 for every class except STORE and BRANCH.
  - wb_sel: LOAD 01; JAL/JALR 10; LUI 11; all others 00.
  - pc_sel: JAL 01; JALR 10; BRANCH 01 if taken, else 00; all others 00.
- **TRAP**: all controls 0; trap = 1 with trap_cause held. The only exit is reset.
- **Handshakes**: req is held high until the matching ack. An ack seen while its req is low is ignored. A req drops in the cycle after its ack.
- **Retire counter**: RETIRE_W bits, wraps modulo 2^RETIRE_W, never saturates.

## Timing
- All state changes occur on the rising edge of clk. rst_n asynchronously forces IDLE at any point, including mid-MEM with dmem_req high.
- Reset values: state IDLE, every output 0, retired 0, wait counter 0.
- dmem_req and imem_req deassert combinationally with reset assertion.
- Zero-wait cycle counts: ALU, branch, jump, LUI and AUIPC take 4 cycles (FETCH, DECODE, EXEC, WB); LOAD and STORE take 5.
- Each wait cycle on a memory port adds one cycle.
- Wait counter: cleared on MEM entry, counts each cycle in MEM without ack, width $clog2(MEM_TIMEOUT+1).
- The first imem_req occurs in the second cycle after rst_n rises.

## Structure
- Package ctrl_pkg holds:
  - the opcode localparams;
  - the state enum;
  - the instruction-class enum;
  - the wb_sel, pc_sel and trap_cause encodings.
- Sub-module instr_classifier: combinational opcode/funct3 to class plus legal bit; instantiated once for DECODE.

## Test plan
- ADDI (opcode 0010011, funct3 0), zero-wait acks -> FETCH/DECODE/EXEC/WB over 4 cycles; WB has reg_w_en = 1, reg_imm_sel = 1 in EXEC, wb_sel = 00, pc_sel = 00; retired goes 0 -> 1.
- LW with dmem_ack delayed 3 cycles -> dmem_req high 4 cycles with dmem_we = 0; WB wb_sel = 01; total 8 cycles.
- SW, then BEQ with branch_taken = 1, then BEQ with branch_taken = 0:
  - SW: dmem_we = 1 and reg_w_en = 0 in WB.
  - Taken BEQ: pc_sel = 01.
  - Not-taken BEQ: pc_sel = 00.
- JALR with funct3 = 1 -> TRAP, trap_cause = 01. Opcode 1111111 -> TRAP, trap_cause = 01. Both hold until reset.
- MEM_TIMEOUT = 4, dmem_ack never asserted -> TRAP with cause 10 after 4 MEM cycles. Rerun with ack on the 4th cycle -> WB, no trap.
- rst_n pulsed low mid-MEM -> all outputs 0 immediately, then IDLE, then FETCH. RETIRE_W = 4 after 16 retirements -> retired wraps to 0.
